// File: rtl/hash_bucket_update_pkg.sv
// Shared slot layout, ingress entry format and FSM states for the hash bucket updater.
package hash_bucket_update_pkg;

    localparam int unsigned SLOT_W  = 256;
    localparam int unsigned KEY_W   = 200;
    localparam int unsigned IDX_W   = 32;
    localparam int unsigned CTR_W   = 2;
    localparam int unsigned ENTRY_W = KEY_W + IDX_W + CTR_W;

    localparam int unsigned OCC_BIT = 255;
    localparam int unsigned KEY_LSB = 0;
    localparam int unsigned CNT_LSB = 200;

    localparam logic [CTR_W-1:0] CTR_BUBBLE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_EVAL,
        ST_WR,
        ST_RES
    } state_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] index;
        logic [CTR_W-1:0] ctr;
    } entry_t;

endpackage

// File: rtl/hash_bucket_update_fifo.sv
// Synchronous first-word-fall-through skid FIFO; DEPTH must be a power of two.
module hash_upd_fifo #(
    parameter int unsigned WIDTH = 234,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/hash_bucket_update.sv
// Read-modify-write count update on an external open-addressed hash table with linear probing;
// one entry in flight, input order preserved, stall back to the hash stage from the skid FIFO.
module hash_bucket_update
    import hash_bucket_update_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_PROBE  = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key_in,
    input  logic [IDX_W-1:0]   index_in,
    input  logic [CTR_W-1:0]   ctr_in,
    input  logic [IDX_W-1:0]   table_size,
    output logic               stall,
    output logic               mem_rd_req,
    output logic               mem_wr_req,
    output logic [IDX_W-1:0]   mem_addr,
    output logic [SLOT_W-1:0]  mem_wr_data,
    input  logic               mem_rd_ack,
    input  logic               mem_wr_ack,
    input  logic               mem_rsp_valid,
    input  logic [SLOT_W-1:0]  mem_rsp_data,
    output logic               res_valid,
    output logic [KEY_W-1:0]   res_key,
    output logic [IDX_W-1:0]   res_index,
    output logic [CNT_W-1:0]   res_count,
    output logic [CTR_W-1:0]   res_ctr,
    output logic               res_overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = $clog2(MAX_PROBE) + 1;
    localparam logic [CW-1:0] STALL_CNT  = CW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] LAST_PROBE = PW'(MAX_PROBE - 1);

    state_t           r_state;
    state_t           w_next;
    entry_t           w_fifo_din;
    entry_t           w_fifo_dout;
    logic [CW-1:0]    w_fifo_count;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_push;
    logic             w_pop;

    logic [KEY_W-1:0] r_key;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_home;
    logic [CTR_W-1:0] r_ctr;
    logic [PW-1:0]    r_probes;
    logic             r_occ;
    logic [KEY_W-1:0] r_slot_key;
    logic [CNT_W-1:0] r_slot_cnt;
    logic [SLOT_W-1:0] r_wr_data;
    logic [CNT_W-1:0] r_new_cnt;

    logic [KEY_W-1:0] r_res_key;
    logic [IDX_W-1:0] r_res_index;
    logic [CNT_W-1:0] r_res_count;
    logic [CTR_W-1:0] r_res_ctr;
    logic             r_res_ovf;

    logic             w_match;
    logic             w_take;
    logic [CNT_W-1:0] w_new_cnt;
    logic [IDX_W-1:0] w_idx_inc;
    logic [IDX_W-1:0] w_next_idx;
    logic [SLOT_W-1:0] w_wr_data;
    logic             w_unused;

    assign w_push     = (ctr_in != CTR_BUBBLE);
    assign w_fifo_din = '{key: key_in, index: index_in, ctr: ctr_in};

    hash_upd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // Raised one entry early: the hash stage still delivers one entry the cycle stall rises.
    assign stall = (w_fifo_count >= STALL_CNT);

    assign w_match    = r_occ && (r_slot_key == r_key);
    assign w_take     = !r_occ || w_match;
    assign w_new_cnt  = !r_occ ? CNT_W'(1) :
                        (&r_slot_cnt) ? r_slot_cnt : r_slot_cnt + 1'b1;
    assign w_idx_inc  = r_idx + 32'd1;
    assign w_next_idx = (w_idx_inc == table_size) ? '0 : w_idx_inc;

    always_comb begin
        w_wr_data                      = '0;
        w_wr_data[OCC_BIT]             = 1'b1;
        w_wr_data[CNT_LSB +: CNT_W]    = w_new_cnt;
        w_wr_data[KEY_LSB +: KEY_W]    = r_key;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_RD;
                end
            end
            ST_RD:   if (mem_rd_ack) w_next = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid) w_next = ST_EVAL;
            ST_EVAL: begin
                if (w_take)                       w_next = ST_WR;
                else if (r_probes == LAST_PROBE)  w_next = ST_RES;
                else                              w_next = ST_RD;
            end
            ST_WR:   if (mem_wr_ack) w_next = ST_RES;
            ST_RES:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_idx       <= '0;
            r_home      <= '0;
            r_ctr       <= '0;
            r_probes    <= '0;
            r_occ       <= 1'b0;
            r_slot_key  <= '0;
            r_slot_cnt  <= '0;
            r_wr_data   <= '0;
            r_new_cnt   <= '0;
            r_res_key   <= '0;
            r_res_index <= '0;
            r_res_count <= '0;
            r_res_ctr   <= '0;
            r_res_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_key    <= w_fifo_dout.key;
                        r_idx    <= w_fifo_dout.index;
                        r_home   <= w_fifo_dout.index;
                        r_ctr    <= w_fifo_dout.ctr;
                        r_probes <= '0;
                    end
                end
                // Responses arriving in any other state are stale and dropped here.
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_occ      <= mem_rsp_data[OCC_BIT];
                        r_slot_key <= mem_rsp_data[KEY_LSB +: KEY_W];
                        r_slot_cnt <= mem_rsp_data[CNT_LSB +: CNT_W];
                    end
                end
                ST_EVAL: begin
                    if (w_take) begin
                        r_wr_data <= w_wr_data;
                        r_new_cnt <= w_new_cnt;
                    end else if (r_probes != LAST_PROBE) begin
                        r_idx    <= w_next_idx;
                        r_probes <= r_probes + 1'b1;
                    end else begin
                        r_res_key   <= r_key;
                        r_res_index <= r_home;
                        r_res_count <= '0;
                        r_res_ctr   <= r_ctr;
                        r_res_ovf   <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (mem_wr_ack) begin
                        r_res_key   <= r_key;
                        r_res_index <= r_idx;
                        r_res_count <= r_new_cnt;
                        r_res_ctr   <= r_ctr;
                        r_res_ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_req   = (r_state == ST_RD);
    assign mem_wr_req   = (r_state == ST_WR);
    assign mem_addr     = r_idx;
    assign mem_wr_data  = r_wr_data;
    assign res_valid    = (r_state == ST_RES);
    assign res_key      = r_res_key;
    assign res_index    = r_res_index;
    assign res_count    = r_res_count;
    assign res_ctr      = r_res_ctr;
    assign res_overflow = r_res_ovf;

    assign w_unused = ^{mem_rsp_data[OCC_BIT-1:CNT_LSB+CNT_W], w_fifo_full};

endmodule
